// File: rtl/fire_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fire_alloc_pkg
// Brief    : Shared key constants and width helper for the fire allocator.
// Revision : 1.0 - initial release
// ============================================================================
package fire_alloc_pkg;

    localparam int              KEY_W               = 8;
    localparam logic [KEY_W-1:0] KEY_NONE            = 8'h00;
    localparam logic [KEY_W-1:0] DEFAULT_FIRE_KEY_T1 = 8'h14;
    localparam logic [KEY_W-1:0] DEFAULT_FIRE_KEY_T2 = 8'h28;

    // Ceiling log2, never below 1 so degenerate counters still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fire_allocator_slot_picker.sv
`default_nettype none
// ============================================================================
// Module   : slot_picker
// Brief    : Picks the first free slot at or after a start index, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module slot_picker #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     free_mask,
    input  logic [IDX_W-1:0] start_idx,
    output logic [N-1:0]     grant,
    output logic             valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid && free_mask[j] && (((int'(start_idx) + i) % N) == j)) begin
                    grant[j] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fire_allocator.sv
`default_nettype none
// ============================================================================
// Module   : fire_allocator
// Brief    : Per-frame fire-key edge detector and bullet slot allocator with
//            cooldown and claim reservation. Define FIRE_ALLOC_ROUND_ROBIN_EN
//            for round-robin slot search instead of lowest-index.
// Revision : 1.0 - initial release
// ============================================================================
module fire_allocator
    import fire_alloc_pkg::*;
#(
    parameter int NUM_TANKS        = 2,
    parameter int BULLETS_PER_TANK = 3,
    parameter int NUM_PORTS        = 6,
    parameter int COOLDOWN_FRAMES  = 8,
    parameter int CLAIM_FRAMES     = 2
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  frame_en,
    input  logic [NUM_PORTS*KEY_W-1:0]            keycodes,
    input  logic [NUM_TANKS*KEY_W-1:0]            fire_keys,
    input  logic [NUM_TANKS*BULLETS_PER_TANK-1:0] bullet_busy,
    output logic [NUM_TANKS*BULLETS_PER_TANK-1:0] trigger,
    output logic [NUM_TANKS-1:0]                  dropped,
    output logic [NUM_TANKS-1:0]                  cooldown_active
);

    localparam int BPT   = BULLETS_PER_TANK;
    localparam int IDX_W = clog2(BPT);
    localparam int CD_W  = clog2(COOLDOWN_FRAMES + 1);
    localparam int AGE_W = clog2(CLAIM_FRAMES + 1);

    logic [NUM_TANKS-1:0] w_pressed;
    logic [NUM_TANKS-1:0] w_edge;
    logic [NUM_TANKS-1:0] r_pressed_q;

    always_comb begin
        w_pressed = '0;
        for (int t = 0; t < NUM_TANKS; t++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ((fire_keys[t*KEY_W +: KEY_W] != KEY_NONE) &&
                    (keycodes[p*KEY_W +: KEY_W] == fire_keys[t*KEY_W +: KEY_W])) begin
                    w_pressed[t] = 1'b1;
                end
            end
        end
    end

    assign w_edge = w_pressed & ~r_pressed_q;

    // History resets high so a key held through reset cannot fire.
    always_ff @(posedge Clk) begin
        if (Reset)         r_pressed_q <= '1;
        else if (frame_en) r_pressed_q <= w_pressed;
    end

    for (genvar t = 0; t < NUM_TANKS; t++) begin : g_tank
        localparam int BASE = t * BPT;

        logic [BPT-1:0]   r_claim;
        logic [AGE_W-1:0] r_age [BPT];
        logic [CD_W-1:0]  r_cd;
        logic [BPT-1:0]   r_trig;
        logic             r_drop;
        logic [BPT-1:0]   w_free;
        logic [BPT-1:0]   w_grant;
        logic [IDX_W-1:0] w_start;
        logic             w_valid;
        logic             w_ready;
        logic             w_accept;
        logic             w_drop;

        assign w_free   = ~bullet_busy[BASE +: BPT] & ~r_claim;
        assign w_ready  = frame_en && w_edge[t] && (r_cd == '0);
        assign w_accept = w_ready && w_valid;
        assign w_drop   = w_ready && !w_valid;

`ifdef FIRE_ALLOC_ROUND_ROBIN_EN
        logic [IDX_W-1:0] r_last;
        logic [IDX_W-1:0] w_grant_idx;

        always_comb begin
            w_grant_idx = '0;
            for (int s = 0; s < BPT; s++) begin
                if (w_grant[s]) w_grant_idx = IDX_W'(s);
            end
        end

        assign w_start = (r_last == IDX_W'(BPT - 1)) ? '0 : r_last + 1'b1;

        always_ff @(posedge Clk) begin
            if (Reset)         r_last <= IDX_W'(BPT - 1);
            else if (w_accept) r_last <= w_grant_idx;
        end
`else
        assign w_start = '0;
`endif

        slot_picker #(
            .N     (BPT),
            .IDX_W (IDX_W)
        ) u_picker (
            .free_mask (w_free),
            .start_idx (w_start),
            .grant     (w_grant),
            .valid     (w_valid)
        );

        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_cd   <= '0;
                r_trig <= '0;
                r_drop <= 1'b0;
            end else begin
                r_trig <= w_accept ? w_grant : '0;
                r_drop <= w_drop;
                if (w_accept)                    r_cd <= CD_W'(COOLDOWN_FRAMES);
                else if (frame_en && r_cd != '0) r_cd <= r_cd - 1'b1;
            end
        end

        // A claim covers the gap until the bullet reports busy; it ages out
        // if busy never rises.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                r_claim <= '0;
                for (int s = 0; s < BPT; s++) r_age[s] <= '0;
            end else begin
                for (int s = 0; s < BPT; s++) begin
                    if (bullet_busy[BASE + s]) begin
                        r_claim[s] <= 1'b0;
                        r_age[s]   <= '0;
                    end else if (frame_en) begin
                        if (w_accept && w_grant[s]) begin
                            r_claim[s] <= 1'b1;
                            r_age[s]   <= '0;
                        end else if (r_claim[s]) begin
                            if (int'(r_age[s]) + 1 >= CLAIM_FRAMES) begin
                                r_claim[s] <= 1'b0;
                                r_age[s]   <= '0;
                            end else begin
                                r_age[s] <= r_age[s] + 1'b1;
                            end
                        end
                    end
                end
            end
        end

        assign trigger[BASE +: BPT] = r_trig;
        assign dropped[t]           = r_drop;
        assign cooldown_active[t]   = (r_cd != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_fire_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_allocator
// Brief    : Self-checking bench for fire_allocator (default and zero-cooldown
//            instances) against a frame-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fire_allocator;
    import fire_alloc_pkg::*;

    localparam int NT    = 2;
    localparam int BPT   = 3;
    localparam int NS    = NT * BPT;
    localparam int NP    = 6;
    localparam int CLAIM = 2;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            frame_en = 1'b0;
    logic [NP*8-1:0] keycodes = '0;
    logic [NT*8-1:0] fire_keys = '0;
    logic [NS-1:0]   bullet_busy = '0;

    logic [NS-1:0] trig [2];
    logic [NT-1:0] drop [2];
    logic [NT-1:0] cda  [2];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fire_allocator dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_en        (frame_en),
        .keycodes        (keycodes),
        .fire_keys       (fire_keys),
        .bullet_busy     (bullet_busy),
        .trigger         (trig[0]),
        .dropped         (drop[0]),
        .cooldown_active (cda[0])
    );

    fire_allocator #(.COOLDOWN_FRAMES(0)) dut_nocd (
        .Clk             (Clk),
        .Reset           (Reset),
        .frame_en        (frame_en),
        .keycodes        (keycodes),
        .fire_keys       (fire_keys),
        .bullet_busy     (bullet_busy),
        .trigger         (trig[1]),
        .dropped         (drop[1]),
        .cooldown_active (cda[1])
    );

    // Reference model: cooldown and claim expressed as frame-number distances.
    bit            m_prev     [2][NT];
    int            m_last_acc [2][NT];
    int            m_last_rr  [2][NT];
    bit            m_claimed  [2][NS];
    int            m_claim_fr [2][NS];
    int            frame_n = 0;
    logic [NS-1:0] e_trig [2];
    logic [NT-1:0] e_drop [2];
    logic [NT-1:0] e_cda  [2];

    task automatic model_step(input bit rst, input bit fe);
        bit           pressed, edge_t, found;
        bit [BPT-1:0] free_m;
        int           base, start, s, pick, cool;
        if (!rst && fe) frame_n++;
        for (int k = 0; k < 2; k++) begin
            cool = (k == 0) ? 8 : 0;
            e_trig[k] = '0;
            e_drop[k] = '0;
            e_cda[k]  = '0;
            for (int t = 0; t < NT; t++) begin
                base = t * BPT;
                if (rst) begin
                    m_prev[k][t]     = 1'b1;
                    m_last_acc[k][t] = -1000;
                    m_last_rr[k][t]  = BPT - 1;
                    for (int j = 0; j < BPT; j++) m_claimed[k][base+j] = 1'b0;
                end else if (fe) begin
                    pressed = 1'b0;
                    for (int p = 0; p < NP; p++) begin
                        if (fire_keys[t*8 +: 8] != 8'h00 && keycodes[p*8 +: 8] == fire_keys[t*8 +: 8])
                            pressed = 1'b1;
                    end
                    edge_t = pressed && !m_prev[k][t];
                    m_prev[k][t] = pressed;
                    for (int j = 0; j < BPT; j++)
                        free_m[j] = !bullet_busy[base+j] &&
                                    !(m_claimed[k][base+j] && frame_n <= m_claim_fr[k][base+j] + CLAIM);
                    if (edge_t && (frame_n - m_last_acc[k][t]) > cool) begin
`ifdef FIRE_ALLOC_ROUND_ROBIN_EN
                        start = (m_last_rr[k][t] + 1) % BPT;
`else
                        start = 0;
`endif
                        found = 1'b0;
                        pick  = 0;
                        for (int i = 0; i < BPT; i++) begin
                            s = (start + i) % BPT;
                            if (!found && free_m[s]) begin
                                found = 1'b1;
                                pick  = s;
                            end
                        end
                        if (found) begin
                            e_trig[k][base+pick]       = 1'b1;
                            m_claimed[k][base+pick]    = 1'b1;
                            m_claim_fr[k][base+pick]   = frame_n;
                            m_last_acc[k][t]           = frame_n;
                            m_last_rr[k][t]            = pick;
                        end else begin
                            e_drop[k][t] = 1'b1;
                        end
                    end
                end
                if (!rst) begin
                    for (int j = 0; j < BPT; j++)
                        if (bullet_busy[base+j]) m_claimed[k][base+j] = 1'b0;
                end
                e_cda[k][t] = (frame_n - m_last_acc[k][t]) < cool;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit fe);
        Reset    = rst;
        frame_en = fe;
        model_step(rst, fe);
        @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("trigger[%0d]", k), 32'(trig[k]), 32'(e_trig[k]));
            check($sformatf("dropped[%0d]", k), 32'(drop[k]), 32'(e_drop[k]));
            check($sformatf("cooldown[%0d]", k), 32'(cda[k]), 32'(e_cda[k]));
        end
        Reset    = 1'b0;
        frame_en = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
        end
    endtask

    task automatic set_port(input int p, input logic [7:0] v);
        keycodes[p*8 +: 8] = v;
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)      return DEFAULT_FIRE_KEY_T1;
        else if (r < 6) return DEFAULT_FIRE_KEY_T2;
        else if (r < 8) return KEY_NONE;
        else            return 8'($urandom_range(1, 255));
    endfunction

    initial begin
        fire_keys = {DEFAULT_FIRE_KEY_T2, DEFAULT_FIRE_KEY_T1};
        repeat (3) cycle(1'b1, 1'b0);
        check("reset_trigger", 32'(trig[0]), 32'd0);
        check("reset_cooldown", 32'(cda[0]), 32'd0);
        frames(2);

        // Single press: slot 0 one cycle after frame_en, cooldown starts.
        set_port(2, 8'h14);
        cycle(1'b0, 1'b1);
        check("first_shot", 32'(trig[0]), 32'b000001);
        check("first_cd", 32'(cda[0]), 32'b01);
        cycle(1'b0, 1'b0);
        check("trig_pulse_end", 32'(trig[0]), 32'd0);
        bullet_busy[0] = 1'b1;
        frames(20);
        set_port(2, 8'h00);
        frames(2);
        set_port(2, 8'h14);
        cycle(1'b0, 1'b1);
        check("second_shot_slot1", 32'(trig[0]), 32'b000010);
        cycle(1'b0, 1'b0);

        // No free slot: drop, no cooldown.
        set_port(2, 8'h00);
        bullet_busy[2:0] = 3'b111;
        frames(10);
        set_port(2, 8'h14);
        cycle(1'b0, 1'b1);
        check("drop_pulse", 32'(drop[0]), 32'b01);
        check("drop_no_trig", 32'(trig[0]), 32'd0);
        check("drop_no_cd", 32'(cda[0]), 32'd0);
        cycle(1'b0, 1'b0);
        check("drop_pulse_end", 32'(drop[0]), 32'd0);

        // Both tanks in one frame.
        bullet_busy = '0;
        set_port(2, 8'h00);
        frames(2);
        set_port(0, 8'h14);
        set_port(5, 8'h28);
        cycle(1'b0, 1'b1);
`ifdef FIRE_ALLOC_ROUND_ROBIN_EN
        check("both_tanks", 32'(trig[0]), 32'b001100);
`else
        check("both_tanks", 32'(trig[0]), 32'b001001);
`endif
        cycle(1'b0, 1'b0);
        set_port(0, 8'h00);
        set_port(5, 8'h00);
        frames(10);

        // Claim reservation on the zero-cooldown instance.
        set_port(0, 8'h14);
        cycle(1'b0, 1'b1);
        check("claim_first", 32'(trig[1]), 32'b000001);
        cycle(1'b0, 1'b0);
        set_port(0, 8'h00);
        frames(1);
        set_port(0, 8'h14);
        cycle(1'b0, 1'b1);
        check("claim_blocks_slot0", 32'(trig[1]), 32'b000010);
        cycle(1'b0, 1'b0);
        set_port(0, 8'h00);
        frames(1);
        set_port(0, 8'h14);
        cycle(1'b0, 1'b1);
`ifdef FIRE_ALLOC_ROUND_ROBIN_EN
        check("claim_expired", 32'(trig[1]), 32'b000100);
`else
        check("claim_expired", 32'(trig[1]), 32'b000001);
`endif
        cycle(1'b0, 1'b0);

        // Reset while the key is held: must release and re-press.
        frames(12);
        cycle(1'b1, 1'b1);
        check("rst_trig", 32'(trig[0]), 32'd0);
        check("rst_cd", 32'(cda[0]), 32'd0);
        frames(12);
        set_port(0, 8'h00);
        frames(1);
        set_port(0, 8'h14);
        cycle(1'b0, 1'b1);
        check("post_rst_shot", 32'(trig[0]), 32'b000001);
        cycle(1'b0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) cycle(1'b1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 19) == 0) fire_keys = {rand_key(), rand_key()};
            for (int p = 0; p < NP; p++) set_port(p, rand_key());
            for (int s = 0; s < NS; s++)
                if ($urandom_range(0, 3) == 0) bullet_busy[s] = ~bullet_busy[s];
            cycle(1'b0, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 2) == 0) bullet_busy[$urandom_range(0, NS-1)] = 1'($urandom_range(0, 1));
                cycle(1'b0, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fire_allocator.md
Name: fire_allocator

Overview:
Parametrised shot-request allocator for the tank game. It scans the USB keycode ports once per frame and detects a rising edge of each tank's fire key. Each accepted shot is mapped to a free bullet slot owned by that tank, and the block emits a one-cycle trigger to that bullet instance. Sits between the keycode PIO exports and the bullet instances. Generalises the two-tank / three-bullet trigger logic to N tanks, M bullets per tank and K ports, and adds cooldown, slot claiming and drop reporting.

Parameters:
NUM_TANKS, 2, number of tanks (fire channels)
BULLETS_PER_TANK, 3, bullet slots owned by each tank; tank t owns slots t*BULLETS_PER_TANK .. t*BULLETS_PER_TANK+BULLETS_PER_TANK-1
NUM_PORTS, 6, keycode ports scanned per frame
COOLDOWN_FRAMES, 8, frames between accepted shots per tank; 0 disables cooldown
CLAIM_FRAMES, 2, frames a claimed slot stays reserved if its busy flag never rises

Ports:
Clk  input  1  system clock (MAX10_CLK1_50 domain)
Reset  input  1  synchronous, active-high reset
frame_en  input  1  one-Clk-cycle pulse per video frame (VS edge already synchronised)
keycodes  input  NUM_PORTS*8  packed keycodes; port p is [8p+7:8p]
fire_keys  input  NUM_TANKS*8  fire keycode per tank; 8'h00 disables the tank
bullet_busy  input  NUM_TANKS*BULLETS_PER_TANK  per-slot "shot in flight" flag from the bullet instances
trigger  output  NUM_TANKS*BULLETS_PER_TANK  one-Clk-cycle launch pulse per slot
dropped  output  NUM_TANKS  one-Clk-cycle pulse: edge accepted but no free slot
cooldown_active  output  NUM_TANKS  high while the tank's cooldown counter is nonzero

Behaviour:
- Reset: trigger=0, dropped=0, cooldown_active=0, cooldown counters=0, claim bits=0. The pressed_q history resets to all-ones, so a key held through reset must be released before it fires. Reset overrides frame_en in the same cycle.
- All state advances only on cycles where frame_en=1; outputs are registered.
- pressed[t] = (fire_keys[t] != 0) AND (some port p has keycodes[p] == fire_keys[t]). Duplicate matches on several ports count once.
- edge[t] = pressed[t] & ~pressed_q[t]. pressed_q[t] updates on every frame_en.
- Per tank, on frame_en:
  - free[s] = ~bullet_busy[s] & ~claim[s] for s in the tank's slot range.
  - If edge[t] and cooldown[t]==0 and at least one slot is free:
    - pick one slot (lowest index; see the optional feature)
    - trigger[s]=1 on the next Clk cycle (latency 1 cycle after frame_en); exactly one bit per tank
    - set claim[s]; load cooldown[t]=COOLDOWN_FRAMES
  - If edge[t] and cooldown[t]==0 and no slot is free: dropped[t]=1 next cycle; cooldown is not loaded.
  - If edge[t] and cooldown[t]!=0: the edge is ignored, with no trigger and no dropped pulse. The key must be re-pressed after cooldown.
  - If cooldown[t]!=0 and no new load occurs: decrement by 1, saturating at 0.
- Claim lifetime: claim[s] clears on any cycle where bullet_busy[s]=1. Otherwise it clears after CLAIM_FRAMES frame_en pulses, tracked by a per-slot age counter of width clog2(CLAIM_FRAMES+1). This prevents double-allocation while the bullet module latches the trigger.
- Trigger and dropped return to 0 on the cycle after the pulse regardless of frame_en.
- Tanks are fully independent. If both tanks use the same fire key, both fire in the same frame.
- A bullet_busy bit that falls mid-cooldown makes the slot free immediately; only cooldown gates the next shot.

Optional Feature:
- Macro: FIRE_ALLOC_ROUND_ROBIN_EN.
- Defined: each tank keeps a last-allocated index. The search starts at (last+1) mod BULLETS_PER_TANK and wraps to the first free slot. last resets to BULLETS_PER_TANK-1, so the first shot uses slot 0.
- Undefined: the lowest-index free slot is chosen and no last-index register exists.

Decomposition:
- fire_alloc_pkg holds:
  - KEY_W=8 and KEY_NONE=8'h00
  - DEFAULT_FIRE_KEY_T1=8'h14 and DEFAULT_FIRE_KEY_T2=8'h28
  - a function returning clog2 for the counter widths
- Sub-module slot_picker: combinational free-mask in, start index in, one-hot grant and valid out. It is instantiated once per tank, and the round-robin start input is tied to 0 when the feature is off.

Test Plan:
- fire_keys={28,14}, all slots idle, port2=8'h14 for one frame → trigger[0] pulses 1 cycle after frame_en; cooldown_active[0]=1 for 8 frames; trigger[3..5] stay 0.
- Key 8'h14 held 20 frames → exactly one trigger. Release, then press again after cooldown ends → trigger[1] (slot 0 still busy); round-robin build → trigger[1] too.
- bullet_busy[2:0]=3'b111, press 8'h14 → dropped[0]=1 for one cycle, no trigger, cooldown_active[0]=0.
- Same frame: port0=8'h14 and port5=8'h28 → trigger[0] and trigger[3] both pulse in the same cycle.
- Press, trigger[0] issued, bullet_busy[0] never rises; press again before 2 frames elapse → slot 1 chosen; after 2 frames with no busy, slot 0 is reusable.
- Key held, Reset asserted for 1 cycle on a frame_en cycle → no trigger; first trigger only after release and re-press; all outputs 0 during reset.
